// File: rtl/rom_arbiter_pkg.sv
// Purpose: shared constants and helpers for the ROM arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rom_arbiter_pkg;

  // Read latency of the external synchronous ROM, in cycles.
  localparam int ROM_LATENCY = 1;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Width of a requester index / priority pointer (at least one bit).
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin pick starting at ptr, plus the next pointer value.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the grant is taken.
//
// Ports:
//   valid     - request vector
//   ptr       - highest-priority index this cycle
//   grant     - one-hot grant (all zero when nothing is valid)
//   grant_idx - binary index of the grant
//   granted   - any grant this cycle
//   next_ptr  - grant_idx + 1, wrapping at NUM_REQ-1
module rr_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               granted,
  output logic [PTR_W-1:0]   next_ptr
);

  // Scan NUM_REQ positions starting at ptr; the first valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    granted   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!granted && valid[j]) begin
        granted   = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

endmodule

// File: rtl/rom_arbiter.sv
// Purpose: round-robin sharing of one synchronous ROM read port among NUM_REQ requesters.
// Latency: accept at edge T, rsp_valid/rsp_data present for the cycle after edge T+1.
// Backpressure: req_ready is a combinational one-hot grant; responses cannot be stalled.
//
// Ports:
//   clk, rst_n - clock, async active-low reset
//   req_valid  - per-requester read request
//   req_addr   - packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready  - one-hot grant
//   rom_addr   - address to the external ROM (0 when nothing is granted)
//   rom_q      - ROM data, one cycle after rom_addr is sampled
//   rsp_valid  - one-hot single-cycle response owner
//   rsp_data   - shared response data, held between responses
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_q,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_granted;
  logic [PTR_W-1:0]   arb_next_ptr;
  logic               accept;

  // Tag stages: one per ROM latency cycle, then the response stage.
  logic               lat_vld [ROM_LATENCY];
  logic [PTR_W-1:0]   lat_idx [ROM_LATENCY];
  logic               rsp_vld_q;
  logic [PTR_W-1:0]   rsp_idx_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .valid     (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .granted   (arb_granted),
    .next_ptr  (arb_next_ptr)
  );

  // Grants are suppressed while reset is asserted so nothing looks accepted.
  assign req_ready = rst_n ? arb_grant : '0;
  assign accept    = rst_n & arb_granted;

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && arb_grant[i]) rom_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) begin
        lat_vld[s] <= 1'b0;
        lat_idx[s] <= '0;
      end
      rsp_vld_q <= 1'b0;
      rsp_idx_q <= '0;
      rsp_data  <= '0;
    end else begin
      if (accept) ptr_q <= arb_next_ptr;
      lat_vld[0] <= accept;
      lat_idx[0] <= arb_idx;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        lat_vld[s] <= lat_vld[s-1];
        lat_idx[s] <= lat_idx[s-1];
      end
      rsp_vld_q <= lat_vld[ROM_LATENCY-1];
      rsp_idx_q <= lat_idx[ROM_LATENCY-1];
      // Capture only for a real read so rsp_data holds between responses.
      if (lat_vld[ROM_LATENCY-1]) rsp_data <= rom_q;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_vld_q) rsp_valid[rsp_idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Purpose: directed bench for rom_arbiter with a queue scoreboard and negedge monitor.
// Latency: expects each response two cycles after the drive cycle of its accept.
// Backpressure: none modelled; requesters hold valid until granted.
module tb_rom_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [AW-1:0]    rom_addr;
  logic [DW-1:0]    rom_q;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [NR-1:0] owner;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] addr_tab [NR];
  logic [NR-1:0] cont_exp [5];

  rom_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a ^ 8'hC3, a, ~a, a + 8'h5A};
  endfunction

  // External synchronous ROM.
  always @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", rsp_valid, '0);
      end else begin
        e = sb.pop_front();
        check("rsp_owner", rsp_valid, e.owner);
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one cycle of requests, check the grant, queue the response.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] exp_rdy,
                      input bit push, input string tag);
    logic [AW-1:0] exp_addr;
    exp_t          e;
    req_valid = v;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr_tab[i];
    exp_addr = '0;
    for (int i = 0; i < NR; i++) if (exp_rdy[i]) exp_addr = addr_tab[i];
    #3;
    check({tag, "_ready"}, req_ready, exp_rdy);
    check({tag, "_rom_addr"}, rom_addr, exp_addr);
    if (push && exp_rdy != '0) begin
      e.owner = exp_rdy;
      e.data  = rom_word(exp_addr);
      e.cyc   = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    addr_tab  = '{8'h10, 8'h21, 8'h32, 8'h43};
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr_tab[i];
    cont_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state with every requester asking.
    repeat (2) @(posedge clk);
    #4;
    check("rst_ready", req_ready, '0);
    check("rst_rom_addr", rom_addr, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_data", rsp_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full contention from ptr=0: order 0,1,2,3,0, granted on the first edge after release.
    for (int i = 0; i < 5; i++) step(4'b1111, cont_exp[i], 1'b1, "contend");

    // Single read of address 0x05.
    addr_tab[0] = 8'h05;
    step(4'b0001, 4'b0001, 1'b1, "single");
    idle(3);

    // Wrap: grant 2, then 3 and 0 ask -> 3 first, then 0.
    step(4'b0100, 4'b0100, 1'b1, "wrap_g2");
    step(4'b1001, 4'b1000, 1'b1, "wrap_g3");
    step(4'b0001, 4'b0001, 1'b1, "wrap_g0");

    // Idle gap: ptr stays 2 across idles, so 0 beats 1.
    step(4'b0010, 4'b0010, 1'b1, "gap_g1");
    idle(2);
    step(4'b0011, 4'b0001, 1'b1, "gap_g0");
    step(4'b0010, 4'b0010, 1'b1, "gap_g1b");

    // Requester 3 drops before being granted: never granted or answered.
    step(4'b1100, 4'b0100, 1'b1, "drop_g2");
    step(4'b0000, 4'b0000, 1'b1, "drop_none");
    step(4'b0001, 4'b0001, 1'b1, "drop_g0");

    // One requester valid every cycle gets every cycle.
    addr_tab[1] = 8'h7E;
    for (int i = 0; i < 4; i++) step(4'b0010, 4'b0010, 1'b1, "solo");
    idle(4);
    check("rsp_data_hold", rsp_data, rom_word(8'h7E));

    // Reset while a read is in flight: no pulse, pointer back to 0.
    addr_tab[0] = 8'h10;
    step(4'b0001, 4'b0001, 1'b0, "inflight");
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", req_ready, '0);
    check("midrst_rom_addr", rom_addr, '0);
    @(posedge clk);
    #1;
    check("midrst_rsp_valid", rsp_valid, '0);
    check("midrst_rsp_data", rsp_data, '0);
    rst_n = 1'b1;
    step(4'b1111, 4'b0001, 1'b1, "post_rst_ptr0");
    idle(4);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
